// File: rtl/stoch_signed_encode_if.sv
// Load/stream port bundle for the signed stochastic encoder.
// master = fixed-point front end, slave = encoder.
interface stoch_signed_encode_if #(
    parameter int WIDTH    = 8,
    parameter int LEN_BITS = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH:0]      in_value;
    logic [LEN_BITS-1:0] in_len;
    logic                y_p;
    logic                y_m;
    logic                y_valid;
    logic                done;

    modport master (
        output in_valid, in_value, in_len,
        input  in_ready, y_p, y_m, y_valid, done
    );

    modport slave (
        input  in_valid, in_value, in_len,
        output in_ready, y_p, y_m, y_valid, done
    );
endinterface

// File: rtl/stoch_signed_encode.sv
// Signed-channel stochastic bitstream encoder: value -> (y_p, y_m)
// with ones-density |value|/(2^WIDTH-1), Galois LFSR random source.
module stoch_signed_encode #(
    parameter int                WIDTH    = 8,
    parameter logic [WIDTH-1:0]  TAPS     = 8'hB8,
    parameter logic [WIDTH-1:0]  SEED     = 8'hA5,
    parameter int                LEN_BITS = 16
) (
    input logic CLK,
    input logic nRST,
    stoch_signed_encode_if.slave bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]          state;
    logic [WIDTH-1:0]    lfsr;
    logic [WIDTH-1:0]    lfsr_next;
    logic [WIDTH-1:0]    mag;
    logic [WIDTH-1:0]    mag_in;
    logic [WIDTH:0]      neg;
    logic [LEN_BITS-1:0] count;
    logic                sign;
    logic                bit_s;
    logic                accept;
    logic                y_p_q;
    logic                y_m_q;
    logic                y_valid_q;
    logic                done_q;

    // -2^WIDTH has no positive twin; its negation wraps, so clamp to full scale
    always_comb begin
        neg    = -bus.in_value;
        mag_in = bus.in_value[WIDTH-1:0];
        if (bus.in_value[WIDTH]) begin
            mag_in = neg[WIDTH] ? '1 : neg[WIDTH-1:0];
        end
    end

    always_comb begin
        lfsr_next = lfsr >> 1;
        if (lfsr[0]) begin
            lfsr_next = (lfsr >> 1) ^ TAPS;
        end
    end

    assign bit_s        = (lfsr <= mag);
    assign bus.in_ready = (state == S_IDLE);
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.y_p      = y_p_q;
    assign bus.y_m      = y_m_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.done     = done_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= S_IDLE;
            lfsr      <= SEED;
            count     <= '0;
            sign      <= 1'b0;
            mag       <= '0;
            y_p_q     <= 1'b0;
            y_m_q     <= 1'b0;
            y_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            y_p_q     <= 1'b0;
            y_m_q     <= 1'b0;
            y_valid_q <= 1'b0;
            done_q    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (bus.in_len != '0) begin
                            sign  <= bus.in_value[WIDTH];
                            mag   <= mag_in;
                            count <= bus.in_len;
                            state <= S_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    y_valid_q <= 1'b1;
                    y_p_q     <= bit_s & ~sign;
                    y_m_q     <= bit_s & sign;
                    lfsr      <= lfsr_next;
                    count     <= count - LEN_BITS'(1);
                    if (count == LEN_BITS'(1)) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stoch_signed_encode.sv
// Scoreboard bench for stoch_signed_encode: per-bit LFSR model plus
// hand-computed ones counts per stream.
module tb_stoch_signed_encode;
    localparam logic [7:0] SEED = 8'hA5;
    localparam logic [7:0] TAPS = 8'hB8;

    typedef struct {
        int ep;
        int em;
        int en;
    } sum_t;

    logic CLK;
    logic nRST;

    stoch_signed_encode_if #(.WIDTH(8), .LEN_BITS(16)) bus ();

    stoch_signed_encode #(
        .WIDTH(8), .TAPS(TAPS), .SEED(SEED), .LEN_BITS(16)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [2:0] q[$];
    sum_t       sq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cnt = 0;
    int         ones_p = 0;
    int         ones_m = 0;
    logic       prev_done = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] m_lfsr = SEED;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected entry per presented output
    always @(negedge CLK) begin
        if (nRST) begin
            if (bus.y_valid || bus.done) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected output: got p=%b m=%b v=%b d=%b, required none",
                             bus.y_p, bus.y_m, bus.y_valid, bus.done);
                end else begin
                    logic [2:0] e;
                    e = q.pop_front();
                    if ({bus.y_p, bus.y_m, bus.done} != e) begin
                        n_bad++;
                        $display("FAIL stream bit: got p/m/done=%b%b%b, required %b",
                                 bus.y_p, bus.y_m, bus.done, e);
                    end
                end
            end
            if (bus.y_valid) begin
                cnt++;
                if (bus.y_p) ones_p++;
                if (bus.y_m) ones_m++;
            end
            if (bus.y_valid && !prev_valid) begin
                n_cmp++;
                if (prev_done) begin
                    n_bad++;
                    $display("FAIL gap: got stream start right after done, required idle cycle");
                end
            end
            if ((bus.y_p && bus.y_m) || (!bus.y_valid && (bus.y_p || bus.y_m))) begin
                n_cmp++;
                n_bad++;
                $display("FAIL channel invariant: got p=%b m=%b v=%b, required exclusive and gated",
                         bus.y_p, bus.y_m, bus.y_valid);
            end
            if (bus.done) begin
                if (sq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL stream summary: got done, required no stream pending");
                end else begin
                    sum_t s;
                    s = sq.pop_front();
                    check("stream length", cnt, s.en);
                    check("y_p ones", ones_p, s.ep);
                    check("y_m ones", ones_m, s.em);
                end
                cnt    = 0;
                ones_p = 0;
                ones_m = 0;
            end
            prev_done  = bus.done;
            prev_valid = bus.y_valid;
        end else begin
            prev_done  = 1'b0;
            prev_valid = 1'b0;
        end
    end

    task automatic load(input logic [8:0] v, input int len,
                        input int ep, input int em, input bit hold);
        int         w;
        logic       s;
        logic       b;
        logic [8:0] t;
        logic [7:0] mag;
        bus.in_value = v;
        bus.in_len   = 16'(len);
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 2000) begin
            @(posedge CLK);
            #1;
            w++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept wait: got in_ready=0 after %0d cycles, required 1", w);
            bus.in_valid = 1'b0;
            return;
        end
        s   = v[8];
        t   = -v;
        mag = s ? t[7:0] : v[7:0];
        if (v == 9'h100) mag = 8'hFF;
        for (int i = 0; i < len; i++) begin
            b = (m_lfsr <= mag);
            q.push_back({b & ~s, b & s, (i == len - 1)});
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
        end
        if (len == 0) q.push_back(3'b001);
        sq.push_back('{ep: ep, em: em, en: len});
        @(posedge CLK);
        #1;
        check("in_ready after accept", int'(bus.in_ready), (len == 0) ? 1 : 0);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || bus.y_valid) && w < 2000) begin
            @(posedge CLK);
            #1;
            w++;
        end
        check("drain pending bits", q.size(), 0);
    endtask

    initial begin
        nRST         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_value = '0;
        bus.in_len   = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset y_valid", int'(bus.y_valid), 0);
        check("reset y_p|y_m", int'(bus.y_p | bus.y_m), 0);
        check("reset done", int'(bus.done), 0);
        check("reset in_ready", int'(bus.in_ready), 1);
        nRST = 1'b1;

        load(9'd64, 255, 64, 0, 0);
        load(9'h138, 255, 0, 200, 0);
        load(9'h100, 255, 0, 255, 0);
        load(9'd0, 10, 0, 0, 0);
        drain();

        load(9'd7, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        check("in_ready after len0", int'(bus.in_ready), 1);
        check("no valid after len0", int'(bus.y_valid), 0);

        load(9'd255, 20, 20, 0, 1);
        load(9'h101, 5, 0, 5, 0);
        drain();

        load(9'd255, 3, 3, 0, 0);
        load(9'd1, 255, 1, 0, 0);
        drain();

        load(9'd100, 100, 0, 0, 0);
        repeat (40) @(posedge CLK);
        #1;
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        q.delete();
        sq.delete();
        cnt    = 0;
        ones_p = 0;
        ones_m = 0;
        check("abort y_valid", int'(bus.y_valid), 0);
        check("abort done", int'(bus.done), 0);
        check("abort in_ready", int'(bus.in_ready), 1);
        nRST   = 1'b1;
        m_lfsr = SEED;
        repeat (110) @(posedge CLK);
        #1;
        load(9'd64, 255, 64, 0, 0);
        drain();
        repeat (3) @(posedge CLK);
        #1;
        check("summaries consumed", sq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stoch_signed_encode.md
Name: stoch_signed_encode

Overview:
Transmitter for signed-channel stochastic bitstreams. Converts a two's-complement fixed-point value into a (y_p, y_m) pair whose ones-density encodes magnitude/255 on the channel selected by the sign. Uses an internal Galois LFSR as the random source. Feeds the stochastic arithmetic operators (signed add/sub/max) from a fixed-point front end via a valid/ready load port and a programmable stream length.

Parameters:
WIDTH, 8, magnitude bits; LFSR width; full scale = 2^WIDTH-1.
TAPS, 8'hB8, Galois LFSR feedback mask (x^8+x^6+x^5+x^4+1, maximal length for WIDTH=8).
SEED, 8'hA5, LFSR reset value; must be nonzero.
LEN_BITS, 16, width of the stream-length field.

Ports:
CLK  in  1  clock
nRST  in  1  reset, synchronous, active-low
in_valid  in  1  load request
in_ready  out  1  encoder idle, can accept load
in_value  in  WIDTH+1  signed two's-complement value
in_len  in  LEN_BITS  number of stream bits to emit
y_p  out  1  positive-channel bit
y_m  out  1  negative-channel bit
y_valid  out  1  y_p/y_m carry a stream bit this cycle
done  out  1  one-cycle pulse coinciding with last stream bit

Behaviour:
- Reset (nRST=0 at posedge): state=IDLE, lfsr=SEED, y_p=y_m=y_valid=done=0, count=0, sign=0, mag=0. Reset mid-stream aborts with no done pulse.
- States: IDLE, RUN. in_ready = (state==IDLE), combinational from state.
- IDLE: on posedge with in_valid & in_ready and in_len!=0: capture sign=in_value[WIDTH], mag=|in_value|, count=in_len; go RUN. Most negative value (-2^WIDTH) saturates to mag=2^WIDTH-1.
- Load with in_len==0: stay IDLE, no stream bits; done pulses one cycle after the accepting edge.
- in_valid while busy: ignored; no capture, no queuing.
- RUN, each posedge: bit = (lfsr <= mag); registered outputs y_valid=1, y_p=bit&~sign, y_m=bit&sign; lfsr advances; count decrements. On edge where count==1: done<=1, state<=IDLE.
- Outputs registered. Accept at edge k -> y_valid high in exactly the cycles following edges k+1..k+in_len. done high only in the cycle following edge k+in_len. in_ready high again after edge k+in_len. Earliest next accept at edge k+in_len+1, so streams have at least one idle gap cycle.
- y_p and y_m are never both 1. Both are 0 whenever y_valid=0. mag=0 gives all-zero stream.
- LFSR: advances only in RUN. Holds its state across loads (not reseeded) to decorrelate successive streams. Range 1..2^WIDTH-1, never 0. Over any 255 consecutive RUN cycles (WIDTH=8), each nonzero value occurs exactly once, so the ones count equals mag exactly.
- Galois step: if lfsr[0], lfsr <= (lfsr>>1)^TAPS; else lfsr <= lfsr>>1.

Test Plan:
- Reset then in_value=+64, in_len=255 -> y_valid high exactly 255 cycles; y_p ones = 64; y_m all 0; done single pulse on 255th bit; in_ready 0 during run.
- in_value=-200 (9'h138), in_len=255 -> y_m ones = 200; y_p all 0.
- in_value=-256 (9'h100), in_len=255 -> saturates: y_m ones = 255 (every bit 1); in_value=0, in_len=10 -> 10 valid cycles, all zero, done on 10th.
- in_len=0 load -> no y_valid; done pulses next cycle; in_ready stays 1. in_valid held during a run -> no second capture until in_ready returns; second stream starts with a gap of at least 1 cycle.
- Back-to-back loads +255 (len 3) then +1 (len 255) -> first stream all ones. Second has exactly 1 one, with LFSR continuing from the prior state (not SEED).
- Assert nRST=0 midway through a len=100 stream -> next cycle y_valid=0, done never pulses, in_ready=1, lfsr=SEED.
